uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_if.sv | 39 +++
 rtl/uart_tx.sv | 258 +++++++++++++++++++++++++
 tb/tb_uart_tx.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// ---------------------------------------------------------------------------------------------
// uart_tx_if -- write-side handshake bundle of the UART transmitter.
//
// Signals:
//   uart_tx_en        write strobe (master -> slave)
//   uart_tx_data      byte to enqueue (master -> slave), PAYLOAD_BITS wide
//   uart_tx_ready     FIFO not full (slave -> master)
//   uart_tx_busy      FIFO non-empty or frame in progress (slave -> master)
//   uart_tx_overflow  one-cycle pulse, a write was dropped (slave -> master)
//
// Modports: master (the writer), slave (the transmitter).
// ---------------------------------------------------------------------------------------------
interface uart_tx_if #(
    parameter int unsigned PAYLOAD_BITS = 8
) ();

    logic                    uart_tx_en;
    logic [PAYLOAD_BITS-1:0] uart_tx_data;
    logic                    uart_tx_ready;
    logic                    uart_tx_busy;
    logic                    uart_tx_overflow;

    modport master (
        output uart_tx_en,
        output uart_tx_data,
        input  uart_tx_ready,
        input  uart_tx_busy,
        input  uart_tx_overflow
    );

    modport slave (
        input  uart_tx_en,
        input  uart_tx_data,
        output uart_tx_ready,
        output uart_tx_busy,
        output uart_tx_overflow
    );

endinterface

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------------------------
// uart_tx -- buffered UART transmitter.
//
// Bytes written through the interface are queued in a small FIFO and sent as
// start(0), PAYLOAD_BITS data bits LSB first, optional even parity, STOP_BITS stop bits (1).
// Each line bit lasts CyclesPerBit clocks. Frames queued behind each other go out with no
// idle gap between the last stop bit and the next start bit.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high reset
//   tx_if     uart_tx_if.slave: uart_tx_en / uart_tx_data in,
//             uart_tx_ready / uart_tx_busy / uart_tx_overflow out
//   uart_txd  registered serial line, idle high
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between the data bits
// and the stop bit(s). Without it there is no parity state or logic at all.
// ---------------------------------------------------------------------------------------------
module uart_tx #(
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned CLK_HZ       = 10_000_000,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave tx_if,
    output logic     uart_txd
);

    // Two-step integer division, each step truncating, as the bit timing is defined that way.
    localparam int unsigned CyclesPerBit = (1_000_000_000 / BIT_RATE) / (1_000_000_000 / CLK_HZ);
    localparam int unsigned CycW         = $clog2(CyclesPerBit + 1);
    localparam int unsigned BitMax       = (PAYLOAD_BITS > STOP_BITS) ? PAYLOAD_BITS : STOP_BITS;
    localparam int unsigned BitW         = $clog2(BitMax + 1);
    localparam int unsigned PtrW         = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW         = PtrW + 1;

    localparam logic [CycW-1:0] CycLast  = CycW'(CyclesPerBit - 1);
    localparam logic [BitW-1:0] DataLast = BitW'(PAYLOAD_BITS - 1);
    localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);
    localparam logic [CntW-1:0] CntFull  = CntW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    // ---------------------------------------------------------------------------------------
    // Transmit FIFO
    // ---------------------------------------------------------------------------------------
    logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]         wr_ptr_q;
    logic [PtrW-1:0]         rd_ptr_q;
    logic [CntW-1:0]         count_q;
    logic [CntW-1:0]         count_d;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    push;
    logic                    pop;
    logic [PAYLOAD_BITS-1:0] head;

    // ---------------------------------------------------------------------------------------
    // Serializer state
    // ---------------------------------------------------------------------------------------
    state_e                  state_q;
    logic [CycW-1:0]         cyc_q;
    logic [BitW-1:0]         bit_q;
    logic [PAYLOAD_BITS-1:0] shift_q;
    logic                    txd_q;
    logic                    ovf_q;
    logic                    bit_end;
    logic                    stop_end;
    logic                    line_d;
`ifdef UART_TX_PARITY_EN
    logic                    parity_q;
`endif

    assign fifo_empty = (count_q == '0);
    // Full is judged on the registered count only, so a pop on the same edge does not
    // open room for a write.
    assign fifo_full  = (count_q == CntFull);
    assign head       = mem_q[rd_ptr_q];

    assign bit_end  = (cyc_q == CycLast);
    assign stop_end = (state_q == StStop) && bit_end && (bit_q == StopLast);

    assign push = tx_if.uart_tx_en && !fifo_full;
    // Pop when idle, or at the last cycle of the stop bits so the next start bit follows
    // the stop bit without a gap.
    assign pop  = !fifo_empty && ((state_q == StIdle) || stop_end);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    // Storage needs no reset: the pointers and count decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_if.uart_tx_data;
        end
    end

    // Line level for the bit the FSM is currently in; registered into txd_q, so the line lags
    // the state by one clock while every bit still lasts exactly CyclesPerBit clocks.
    always_comb begin
        line_d = 1'b1;
        unique case (state_q)
            StIdle:   line_d = 1'b1;
            StStart:  line_d = 1'b0;
            StData:   line_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            StParity: line_d = parity_q;
`endif
            StStop:   line_d = 1'b1;
            default:  line_d = 1'b1;
        endcase
    end

    // ---------------------------------------------------------------------------------------
    // Frame FSM with registered outputs
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cyc_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            ovf_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            txd_q <= line_d;
            ovf_q <= tx_if.uart_tx_en && fifo_full;

            unique case (state_q)
                StIdle: begin
                    cyc_q <= '0;
                    bit_q <= '0;
                    if (pop) begin
                        shift_q  <= head;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^head;
`endif
                        state_q  <= StStart;
                    end
                end

                StStart: begin
                    if (bit_end) begin
                        cyc_q   <= '0;
                        state_q <= StData;
                    end else begin
                        cyc_q <= cyc_q + CycW'(1);
                    end
                end

                StData: begin
                    if (bit_end) begin
                        cyc_q   <= '0;
                        shift_q <= shift_q >> 1;
                        if (bit_q == DataLast) begin
                            bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end else begin
                            bit_q <= bit_q + BitW'(1);
                        end
                    end else begin
                        cyc_q <= cyc_q + CycW'(1);
                    end
                end

`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (bit_end) begin
                        cyc_q   <= '0;
                        state_q <= StStop;
                    end else begin
                        cyc_q <= cyc_q + CycW'(1);
                    end
                end
`endif

                StStop: begin
                    if (bit_end) begin
                        cyc_q <= '0;
                        if (bit_q == StopLast) begin
                            bit_q <= '0;
                            // pop is already qualified by stop_end here
                            if (pop) begin
                                shift_q  <= head;
`ifdef UART_TX_PARITY_EN
                                parity_q <= ^head;
`endif
                                state_q  <= StStart;
                            end else begin
                                state_q <= StIdle;
                            end
                        end else begin
                            bit_q <= bit_q + BitW'(1);
                        end
                    end else begin
                        cyc_q <= cyc_q + CycW'(1);
                    end
                end

                default: begin
                    state_q <= StIdle;
                    cyc_q   <= '0;
                    bit_q   <= '0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------------------------
    assign uart_txd               = txd_q;
    assign tx_if.uart_tx_ready    = !fifo_full;
    // Falls on the edge the FSM returns to idle with nothing queued.
    assign tx_if.uart_tx_busy     = (state_q != StIdle) || !fifo_empty;
    assign tx_if.uart_tx_overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx at 10 MHz / 1 Mbit/s (10 clocks per bit).
// A transaction-level model (byte queue, frame end times, frame bit pattern) predicts the
// serial line and the ready/busy/overflow outputs after every clock edge.
// ---------------------------------------------------------------------------------------------
module tb_uart_tx;

    localparam int Cpb   = 10;
    localparam int Depth = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FrameBits = 11;
`else
    localparam int FrameBits = 10;
`endif

    logic clk = 1'b0;
    logic reset;
    logic txd;

    uart_tx_if #(.PAYLOAD_BITS(8)) bus ();

    uart_tx #(
        .BIT_RATE     (1_000_000),
        .CLK_HZ       (10_000_000),
        .PAYLOAD_BITS (8),
        .STOP_BITS    (1),
        .FIFO_DEPTH   (Depth)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_if    (bus),
        .uart_txd (txd)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state
    byte unsigned m_q[$];       // bytes accepted but not yet started
    bit           m_active;     // a frame is being transmitted
    int           m_end;        // edge at which the current frame's stop bits end
    bit           line_valid;
    byte unsigned line_byte;
    int           line_start;   // first edge after which txd carries the start bit
    bit           pend_valid;
    byte unsigned pend_byte;
    int           pend_start;
    int           n_edge;       // index of the next rising edge

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", tag, n_edge, got, exp);
        end
    endtask

    function automatic logic exp_line(input int n);
        int          k;
        logic [7:0]  b;
        if (!line_valid) return 1'b1;
        k = (n - line_start) / Cpb;
        b = line_byte;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_active   = 1'b0;
        m_end      = 0;
        line_valid = 1'b0;
        pend_valid = 1'b0;
    endtask

    // One clock: drive at the falling edge, advance the model for the rising edge, compare.
    task automatic tick(input bit en, input logic [7:0] data);
        bit ovf;
        bit push;
        bit pop;
        @(negedge clk);
        bus.uart_tx_en   = en;
        bus.uart_tx_data = data;
        @(posedge clk);
        ovf  = en && (m_q.size() == Depth);
        push = en && !ovf;
        pop  = (m_q.size() != 0) && (!m_active || n_edge == m_end);
        if (m_active && n_edge == m_end && !pop) m_active = 1'b0;
        if (pend_valid && n_edge == pend_start) begin
            line_valid = 1'b1;
            line_byte  = pend_byte;
            line_start = pend_start;
            pend_valid = 1'b0;
        end
        if (pop) begin
            pend_byte  = m_q.pop_front();
            pend_start = n_edge + 1;
            pend_valid = 1'b1;
            m_active   = 1'b1;
            m_end      = n_edge + FrameBits * Cpb;
        end
        if (push) m_q.push_back(data);
        #1;
        check_val("txd", 32'(txd), 32'(exp_line(n_edge)));
        check_val("ready", 32'(bus.uart_tx_ready), 32'(m_q.size() < Depth));
        check_val("busy", 32'(bus.uart_tx_busy), 32'(m_active || (m_q.size() != 0)));
        check_val("overflow", 32'(bus.uart_tx_overflow), 32'(ovf));
        n_edge++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_txd"}, 32'(txd), 32'd1);
        check_val({tag, "_ready"}, 32'(bus.uart_tx_ready), 32'd1);
        check_val({tag, "_busy"}, 32'(bus.uart_tx_busy), 32'd0);
        check_val({tag, "_ovf"}, 32'(bus.uart_tx_overflow), 32'd0);
    endtask

    initial begin
        int guard;
        int pct;

        model_clear();
        n_edge           = 0;
        bus.uart_tx_en   = 1'b0;
        bus.uart_tx_data = 8'h00;
        reset            = 1'b1;
        #1;
        check_reset_outputs("rst_init");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Single byte from idle.
        tick(1'b1, 8'h55);
        idle(110);

        // Three bytes back to back.
        tick(1'b1, 8'hA3);
        tick(1'b1, 8'h0F);
        tick(1'b1, 8'hFF);
        idle(320);

        // Parity patterns (parity bit only present in the parity build).
        tick(1'b1, 8'h07);
        tick(1'b1, 8'h55);
        idle(230);

        // Six writes in a row: the FIFO fills and the sixth is dropped.
        for (int i = 0; i < 6; i++) tick(1'b1, 8'(8'h30 + i));
        idle(560);

        // Write coinciding with the stop-end pop while three bytes are queued.
        tick(1'b1, 8'h11);
        tick(1'b0, 8'h00);
        tick(1'b1, 8'h22);
        tick(1'b1, 8'h33);
        tick(1'b1, 8'h44);
        guard = 0;
        while (n_edge != m_end && guard < 500) begin
            tick(1'b0, 8'h00);
            guard++;
        end
        check_val("wr_pop_align", 32'(guard < 500), 32'd1);
        tick(1'b1, 8'h5A);
        tick(1'b1, 8'h6B);
        tick(1'b1, 8'h7C);
        idle(560);

        // Reset in the middle of a 0x00 frame with more bytes queued behind it.
        tick(1'b1, 8'h00);
        tick(1'b1, 8'hC3);
        tick(1'b1, 8'h3C);
        idle(34);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        model_clear();
        repeat (2) begin
            @(posedge clk);
            n_edge++;
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        n_edge++;
        idle(300);

        // Random traffic at several write densities.
        for (int ph = 0; ph < 3; ph++) begin
            pct = (ph == 0) ? 4 : ((ph == 1) ? 40 : 95);
            for (int i = 0; i < 700; i++) begin
                tick(($urandom_range(0, 99) < pct), 8'($urandom));
            end
        end
        idle(600);
        check_val("drained_busy", 32'(bus.uart_tx_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
